// File: rtl/fetch_queue_unit_pkg.sv
// Shared constants for the fetch queue unit.
// No ports; imported by the interface and the top level.
package fetch_queue_unit_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0020;
    localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Bus bundle between the fetch queue unit and its environment.
//   imem_*     : instruction memory read port (one-cycle read latency)
//   redirect_* : branch/jump redirect from execute
//   dec_*      : valid/ready drain port toward decode
//   fetch_pc_out : current fetch PC, for observation
// Modport master is the fetch unit side, slave is the environment side.
interface fetch_queue_unit_if
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] dec_instr;
    logic [ADDR_W-1:0]  dec_pc;
    logic [ADDR_W-1:0]  fetch_pc_out;

    modport master (
        output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, fetch_pc_out,
        input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, fetch_pc_out,
        output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Circular prefetch FIFO holding {pc, instr} entries.
//   clk, rst   : clock, asynchronous active-high clear
//   flush      : synchronous flush, overrides push and pop
//   push/push_data : write one entry (caller guarantees space)
//   pop        : drop head entry (caller guarantees non-empty)
//   head_valid/head_data : registered head of queue, zero when empty
//   count      : number of stored entries
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CntW-1:0]  count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push && !flush) mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;
endmodule

// File: rtl/fetch_queue_unit.sv
// Decoupled instruction fetch stage with prefetch FIFO.
//   clk      : clock
//   start_up : asynchronous active-high reset
//   bus      : master side of fetch_queue_unit_if (imem read port,
//              redirect input, decode valid/ready port, fetch_pc_out)
// Requests are credit-limited so buffered plus in-flight entries never
// exceed DEPTH; a redirect flushes the FIFO and drops the in-flight response.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned        DEPTH    = 4
) (
    input  logic                clk,
    input  logic                start_up,
    fetch_queue_unit_if.master  bus
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;
    logic              kill_q, kill_d;

    logic [CntW-1:0]   count;
    logic [CntW:0]     credits;
    logic              issue, push, pop, head_valid;
    logic [ADDR_W+INSTR_W-1:0] head_data;

    assign credits = {1'b0, count} + (CntW + 1)'(inflight_q);
    assign issue   = !start_up && !bus.redirect_valid && (credits < (CntW + 1)'(DEPTH));
    // A response is only trusted if we actually asked for it last cycle.
    assign push    = bus.imem_rvalid && inflight_q && !kill_q && !bus.redirect_valid;
    assign pop     = head_valid && bus.dec_ready && !bus.redirect_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        // Nothing survives a redirect in flight with one-cycle latency.
        kill_d     = 1'b0;
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc & {{(ADDR_W - 2){1'b1}}, 2'b00};
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
            req_pc_d   = fetch_pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge start_up) begin
        if (start_up) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (start_up),
        .flush      (bus.redirect_valid),
        .push       (push),
        .push_data  ({req_pc_q, bus.imem_rdata}),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_data),
        .count      (count)
    );

    assign bus.imem_req     = issue;
    assign bus.imem_addr    = fetch_pc_q;
    assign bus.fetch_pc_out = fetch_pc_q;
    assign bus.dec_valid    = head_valid;
    assign bus.dec_pc       = head_data[ADDR_W+INSTR_W-1:INSTR_W];
    assign bus.dec_instr    = head_data[INSTR_W-1:0];
endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;
    logic clk = 1'b0;
    logic start_up = 1'b1;
    logic mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic force_rvalid = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;
    localparam logic [31:0] RST_PC  = 32'h0040_0020;

    fetch_queue_unit_if #(.ADDR_W(32)) bus ();

    fetch_queue_unit #(
        .ADDR_W   (32),
        .RESET_PC (RST_PC),
        .DEPTH    (4)
    ) dut (
        .clk      (clk),
        .start_up (start_up),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: fixed one-cycle latency, word = addr ^ key.
    always @(posedge clk) begin
        mem_rvalid <= bus.imem_req;
        mem_rdata  <= bus.imem_addr ^ XOR_KEY;
    end
    assign bus.imem_rvalid = mem_rvalid | force_rvalid;
    assign bus.imem_rdata  = mem_rdata;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Ends with start_up released, 1ns into cycle 0.
    task automatic do_reset(input logic ready);
        @(negedge clk);
        start_up = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.dec_ready = ready;
        force_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        start_up = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        start_up = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.dec_ready = 1'b1;
        #1;
        vectors++;
        if (bus.imem_req !== 1'b0) begin
            $display("FAIL rst_req got %b want 0", bus.imem_req); miscompares++;
        end
        vectors++;
        if (bus.dec_valid !== 1'b0) begin
            $display("FAIL rst_dec_valid got %b want 0", bus.dec_valid); miscompares++;
        end
        vectors++;
        if (bus.dec_instr !== 32'h0) begin
            $display("FAIL rst_dec_instr got %h want 0", bus.dec_instr); miscompares++;
        end
        vectors++;
        if (bus.dec_pc !== 32'h0) begin
            $display("FAIL rst_dec_pc got %h want 0", bus.dec_pc); miscompares++;
        end
        vectors++;
        if (bus.fetch_pc_out !== RST_PC) begin
            $display("FAIL rst_fetch_pc got %h want %h", bus.fetch_pc_out, RST_PC);
            miscompares++;
        end
    endtask

    // Also injects a spurious rvalid in cycle 0, which must be ignored.
    task automatic test_sequential(input string tag);
        logic [31:0] e;
        logic [31:0] d;
        do_reset(1'b1);
        force_rvalid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (n > 0) tick();
            if (n == 1) force_rvalid = 1'b0;
            e = RST_PC + 32'(4 * n);
            d = RST_PC + 32'(4 * (n - 2));
            vectors++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== e) begin
                $display("FAIL %s_req n=%0d got req=%b addr=%h want req=1 addr=%h",
                         tag, n, bus.imem_req, bus.imem_addr, e);
                miscompares++;
            end
            vectors++;
            if (bus.dec_valid !== (n >= 2)) begin
                $display("FAIL %s_valid n=%0d got %b want %b", tag, n, bus.dec_valid, n >= 2);
                miscompares++;
            end
            if (n >= 2) begin
                vectors++;
                if (bus.dec_pc !== d || bus.dec_instr !== (d ^ XOR_KEY)) begin
                    $display("FAIL %s_head n=%0d got pc=%h instr=%h want pc=%h instr=%h",
                             tag, n, bus.dec_pc, bus.dec_instr, d, d ^ XOR_KEY);
                    miscompares++;
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] e;
        do_reset(1'b0);
        for (int n = 0; n < 7; n++) begin
            if (n > 0) tick();
            e = (n < 4) ? RST_PC + 32'(4 * n) : 32'h0040_0030;
            vectors++;
            if (bus.imem_req !== (n < 4) || bus.fetch_pc_out !== e) begin
                $display("FAIL bp_fill n=%0d got req=%b pc=%h want req=%b pc=%h",
                         n, bus.imem_req, bus.fetch_pc_out, n < 4, e);
                miscompares++;
            end
        end
        vectors++;
        if (bus.dec_valid !== 1'b1 || bus.dec_pc !== RST_PC) begin
            $display("FAIL bp_full_head got v=%b pc=%h want v=1 pc=%h",
                     bus.dec_valid, bus.dec_pc, RST_PC);
            miscompares++;
        end
        for (int n = 7; n < 12; n++) begin
            tick();
            if (n == 7) bus.dec_ready = 1'b1;
            e = RST_PC + 32'(4 * (n - 7));
            vectors++;
            if (bus.dec_valid !== 1'b1 || bus.dec_pc !== e || bus.dec_instr !== (e ^ XOR_KEY)) begin
                $display("FAIL bp_drain n=%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                         n, bus.dec_valid, bus.dec_pc, bus.dec_instr, e, e ^ XOR_KEY);
                miscompares++;
            end
            if (n == 7) begin
                vectors++;
                if (bus.imem_req !== 1'b0) begin
                    $display("FAIL bp_no_credit got req=%b want 0", bus.imem_req);
                    miscompares++;
                end
            end
            if (n == 8) begin
                vectors++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0030) begin
                    $display("FAIL bp_resume got req=%b addr=%h want req=1 addr=00400030",
                             bus.imem_req, bus.imem_addr);
                    miscompares++;
                end
            end
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset(1'b1);
        repeat (5) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0040_0101;
        #1;
        vectors++;
        if (bus.imem_req !== 1'b0) begin
            $display("FAIL rdi_suppress got req=%b want 0", bus.imem_req); miscompares++;
        end
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0100 || bus.dec_valid !== 1'b0) begin
            $display("FAIL rdi_c6 got req=%b addr=%h v=%b want req=1 addr=00400100 v=0",
                     bus.imem_req, bus.imem_addr, bus.dec_valid);
            miscompares++;
        end
        tick();
        vectors++;
        if (bus.dec_valid !== 1'b0 || bus.imem_addr !== 32'h0040_0104) begin
            $display("FAIL rdi_c7 got v=%b addr=%h want v=0 addr=00400104",
                     bus.dec_valid, bus.imem_addr);
            miscompares++;
        end
        tick();
        vectors++;
        if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h0040_0100
            || bus.dec_instr !== (32'h0040_0100 ^ XOR_KEY)) begin
            $display("FAIL rdi_c8 got v=%b pc=%h instr=%h want v=1 pc=00400100",
                     bus.dec_valid, bus.dec_pc, bus.dec_instr);
            miscompares++;
        end
        tick();
        vectors++;
        if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h0040_0104) begin
            $display("FAIL rdi_c9 got v=%b pc=%h want v=1 pc=00400104",
                     bus.dec_valid, bus.dec_pc);
            miscompares++;
        end
    endtask

    task automatic test_redirect_full();
        do_reset(1'b0);
        repeat (6) tick();
        bus.dec_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0040_0200;
        #1;
        vectors++;
        if (bus.imem_req !== 1'b0 || bus.dec_valid !== 1'b1) begin
            $display("FAIL rdf_t got req=%b v=%b want req=0 v=1", bus.imem_req, bus.dec_valid);
            miscompares++;
        end
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        vectors++;
        if (bus.dec_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0200) begin
            $display("FAIL rdf_t1 got v=%b req=%b addr=%h want v=0 req=1 addr=00400200",
                     bus.dec_valid, bus.imem_req, bus.imem_addr);
            miscompares++;
        end
        tick();
        vectors++;
        if (bus.dec_valid !== 1'b0) begin
            $display("FAIL rdf_t2 got v=%b want 0", bus.dec_valid); miscompares++;
        end
        tick();
        vectors++;
        if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h0040_0200) begin
            $display("FAIL rdf_t3 got v=%b pc=%h want v=1 pc=00400200",
                     bus.dec_valid, bus.dec_pc);
            miscompares++;
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        repeat (2) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        #1;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
            $display("FAIL wrap_a0 got req=%b addr=%h want req=1 addr=fffffffc",
                     bus.imem_req, bus.imem_addr);
            miscompares++;
        end
        tick();
        vectors++;
        if (bus.imem_addr !== 32'h0 || bus.fetch_pc_out !== 32'h0) begin
            $display("FAIL wrap_a1 got addr=%h pc=%h want 0", bus.imem_addr, bus.fetch_pc_out);
            miscompares++;
        end
        tick();
        vectors++;
        if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'hFFFF_FFFC) begin
            $display("FAIL wrap_d0 got v=%b pc=%h want v=1 pc=fffffffc",
                     bus.dec_valid, bus.dec_pc);
            miscompares++;
        end
        tick();
        vectors++;
        if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h0 || bus.dec_instr !== XOR_KEY) begin
            $display("FAIL wrap_d1 got v=%b pc=%h instr=%h want v=1 pc=0 instr=%h",
                     bus.dec_valid, bus.dec_pc, bus.dec_instr, XOR_KEY);
            miscompares++;
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        repeat (4) tick();
        vectors++;
        if (bus.dec_valid !== 1'b1 || bus.fetch_pc_out !== 32'h0040_0030) begin
            $display("FAIL ar_pre got v=%b pc=%h want v=1 pc=00400030",
                     bus.dec_valid, bus.fetch_pc_out);
            miscompares++;
        end
        #2;
        start_up = 1'b1;
        #1;
        vectors++;
        if (bus.dec_valid !== 1'b0 || bus.fetch_pc_out !== RST_PC || bus.imem_req !== 1'b0
            || bus.dec_pc !== 32'h0) begin
            $display("FAIL ar_now got v=%b pc=%h req=%b dpc=%h want v=0 pc=%h req=0 dpc=0",
                     bus.dec_valid, bus.fetch_pc_out, bus.imem_req, bus.dec_pc, RST_PC);
            miscompares++;
        end
        test_sequential("ar_restart");
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.dec_ready = 1'b0;
        test_reset();
        test_sequential("seq");
        test_back_pressure();
        test_redirect_inflight();
        test_redirect_full();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
